// File: rtl/pid_pkg.sv
// rtl/pid_pkg.sv - shared types and helpers for the PID engine
// Purpose: FSM state encoding, configuration register select codes and
//          a signed clamp helper used by the integrator and output stages.
// Ports:   none (package)
package pid_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ERR   = 3'd1,
    S_MUL_P = 3'd2,
    S_MUL_I = 3'd3,
    S_MUL_D = 3'd4,
    S_SAT   = 3'd5,
    S_OUT   = 3'd6
  } pid_state_t;

  typedef enum logic [1:0] {
    SEL_SP = 2'd0,
    SEL_KP = 2'd1,
    SEL_KI = 2'd2,
    SEL_KD = 2'd3
  } cfg_sel_t;

  // Callers sign-extend into 32 bits and truncate the result back down.
  function automatic logic signed [31:0] sclamp(input logic signed [31:0] v,
                                                input logic signed [31:0] lo,
                                                input logic signed [31:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/pid_engine_if.sv
// rtl/pid_engine_if.sv - sample and result handshake bundle for the PID engine
// Purpose: groups the sample input stream and the result output stream.
// Ports:   smp_valid/smp_ready/smp_ch/smp_data - sample stream into the engine
//          out_valid/out_ready/out_ch/out_data - result stream out of the engine
// Modports: master = sample producer / result consumer, slave = engine
interface pid_engine_if #(
  parameter int DW = 8,
  parameter int CW = 1
);
  logic          smp_valid;
  logic          smp_ready;
  logic [CW-1:0] smp_ch;
  logic [DW-1:0] smp_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ch;
  logic [DW-1:0] out_data;

  modport master (
    output smp_valid, smp_ch, smp_data, out_ready,
    input  smp_ready, out_valid, out_ch, out_data
  );

  modport slave (
    input  smp_valid, smp_ch, smp_data, out_ready,
    output smp_ready, out_valid, out_ch, out_data
  );
endinterface

// File: rtl/pid_shift_mul.sv
// rtl/pid_shift_mul.sv - sequential shift-add multiplier, one gain bit per cycle
// Purpose: prod = a * b, signed a, unsigned b, taking exactly GW cycles.
// Ports:   clk, reset - clock and asynchronous active-high reset
//          start      - one-cycle pulse; a and b are sampled in that cycle
//          a, b       - signed multiplicand (AW bits), unsigned multiplier (GW bits)
//          done       - high during the cycle whose closing edge writes the final
//                       partial product; prod holds the result from the next cycle
//          prod       - registered product (AW bits)
module pid_shift_mul #(
  parameter int AW = 18,
  parameter int GW = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic signed [AW-1:0] a,
  input  logic        [GW-1:0] b,
  output logic                 done,
  output logic signed [AW-1:0] prod
);

  localparam int CNW = (GW > 1) ? $clog2(GW) : 1;

  logic                 running;
  logic [CNW-1:0]       cnt;
  logic signed [AW-1:0] mcand;
  logic [GW-1:0]        mplier;

  // The start cycle already consumes gain bit 0, so the remaining GW-1
  // bits take GW-1 further cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running <= 1'b0;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      prod    <= '0;
    end else if (start) begin
      prod    <= b[0] ? a : '0;
      mcand   <= a <<< 1;
      mplier  <= b >> 1;
      cnt     <= CNW'(GW - 1);
      running <= (GW > 1);
    end else if (running) begin
      prod   <= prod + (mplier[0] ? mcand : '0);
      mcand  <= mcand <<< 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNW'(1);
      if (cnt == CNW'(1)) running <= 1'b0;
    end
  end

  assign done = start ? (GW == 1) : (running && (cnt == CNW'(1)));

endmodule

// File: rtl/pid_engine.sv
// rtl/pid_engine.sv - time-multiplexed multi-channel PID controller
// Purpose: per-channel setpoint/gain registers and integrator state; each accepted
//          sample runs ERR -> MUL_P -> MUL_I -> MUL_D -> SAT -> OUT on a shared
//          shift-add multiplier.
// Ports:   clk, reset            - clock, asynchronous active-high reset
//          en                    - sample acceptance enable
//          clr                   - zero all integrators and previous errors
//          cfg_we/cfg_ch/cfg_sel/cfg_data - configuration register write
//          bus (slave)           - sample input and result output handshakes
//          busy                  - high whenever the FSM is not IDLE
module pid_engine
  import pid_pkg::*;
#(
  parameter int DW    = 8,
  parameter int GW    = 4,
  parameter int IW    = 12,
  parameter int CH    = 2,
  parameter int SHIFT = 2,
  localparam int CW   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          clr,
  input  logic          cfg_we,
  input  logic [CW-1:0] cfg_ch,
  input  logic [1:0]    cfg_sel,
  input  logic [DW-1:0] cfg_data,
  pid_engine_if.slave   bus,
  output logic          busy
);

  localparam int AW = IW + GW + 2;
  localparam logic signed [31:0] I_MAX   = (32'sd1 <<< (IW - 1)) - 32'sd1;
  localparam logic signed [31:0] I_MIN   = -(32'sd1 <<< (IW - 1));
  localparam logic signed [31:0] OUT_MAX = (32'sd1 <<< DW) - 32'sd1;

  function automatic logic ch_ok(input logic [CW-1:0] c);
    return 32'(c) < CH;
  endfunction

  logic [DW-1:0]        sp_q    [CH];
  logic [GW-1:0]        kp_q    [CH];
  logic [GW-1:0]        ki_q    [CH];
  logic [GW-1:0]        kd_q    [CH];
  logic signed [IW-1:0] integ_q [CH];
  logic signed [DW:0]   eprev_q [CH];

  pid_state_t           state;
  logic                 start_q;
  logic                 mul_done;
  logic signed [AW-1:0] mul_a, mul_prod, sum_q, total_w, shr_w;
  logic [GW-1:0]        mul_b;

  // Per-sample snapshot so cfg writes during processing affect only later samples.
  logic [CW-1:0]        ch_q;
  logic [DW-1:0]        sp_s, pv_s;
  logic [GW-1:0]        kp_s, ki_s, kd_s;

  logic signed [DW:0]   e_w, e_q, ep_old;
  logic signed [IW-1:0] i_old, i_new, i_q;
  logic signed [DW+1:0] d_w, d_q;
  logic [DW-1:0]        sat_w;

  logic                 out_valid_q;
  logic [CW-1:0]        out_ch_q;
  logic [DW-1:0]        out_data_q;
  logic                 smp_ready_w;

  assign smp_ready_w   = en && (state == S_IDLE) && !reset;
  assign bus.smp_ready = smp_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_data  = out_data_q;
  assign busy          = (state != S_IDLE);

  // Configuration registers; out-of-range channels are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CH; c++) begin
        sp_q[c] <= '0;
        kp_q[c] <= '0;
        ki_q[c] <= '0;
        kd_q[c] <= '0;
      end
    end else if (cfg_we && ch_ok(cfg_ch)) begin
      case (cfg_sel_t'(cfg_sel))
        SEL_SP:  sp_q[cfg_ch] <= cfg_data;
        SEL_KP:  kp_q[cfg_ch] <= cfg_data[GW-1:0];
        SEL_KI:  ki_q[cfg_ch] <= cfg_data[GW-1:0];
        default: kd_q[cfg_ch] <= cfg_data[GW-1:0];
      endcase
    end
  end

  // Error stage. A clr coinciding with ERR makes this sample start from zero history.
  always_comb begin
    e_w    = $signed({1'b0, sp_s}) - $signed({1'b0, pv_s});
    i_old  = clr ? '0 : integ_q[ch_q];
    ep_old = clr ? '0 : eprev_q[ch_q];
    i_new  = IW'(sclamp(32'(i_old) + 32'(e_w), I_MIN, I_MAX));
    d_w    = (DW + 2)'(e_w) - (DW + 2)'(ep_old);
  end

  // Multiplier operand steering; operands only matter in the start cycle.
  always_comb begin
    mul_a = AW'(e_q);
    mul_b = kp_s;
    case (state)
      S_MUL_I: begin
        mul_a = AW'(i_q);
        mul_b = ki_s;
      end
      S_MUL_D: begin
        mul_a = AW'(d_q);
        mul_b = kd_s;
      end
      default: ;
    endcase
  end

  // The D product is still only in mul_prod during SAT, so fold it in here.
  always_comb begin
    total_w = sum_q + mul_prod;
    shr_w   = total_w >>> SHIFT;
    sat_w   = DW'(sclamp(32'(shr_w), 32'sd0, OUT_MAX));
  end

  pid_shift_mul #(
    .AW(AW),
    .GW(GW)
  ) u_mul (
    .clk  (clk),
    .reset(reset),
    .start(start_q),
    .a    (mul_a),
    .b    (mul_b),
    .done (mul_done),
    .prod (mul_prod)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      start_q     <= 1'b0;
      ch_q        <= '0;
      sp_s        <= '0;
      pv_s        <= '0;
      kp_s        <= '0;
      ki_s        <= '0;
      kd_s        <= '0;
      e_q         <= '0;
      i_q         <= '0;
      d_q         <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      for (int c = 0; c < CH; c++) begin
        integ_q[c] <= '0;
        eprev_q[c] <= '0;
      end
    end else begin
      if (clr) begin
        for (int c = 0; c < CH; c++) begin
          integ_q[c] <= '0;
          eprev_q[c] <= '0;
        end
      end
      // Later assignment wins over the clr loop for the channel in ERR.
      if (state == S_ERR) begin
        integ_q[ch_q] <= i_new;
        eprev_q[ch_q] <= e_w;
      end

      start_q <= 1'b0;
      case (state)
        S_IDLE: begin
          // Out-of-range samples are consumed but leave the FSM in IDLE.
          if (bus.smp_valid && smp_ready_w && ch_ok(bus.smp_ch)) begin
            ch_q  <= bus.smp_ch;
            pv_s  <= bus.smp_data;
            sp_s  <= sp_q[bus.smp_ch];
            kp_s  <= kp_q[bus.smp_ch];
            ki_s  <= ki_q[bus.smp_ch];
            kd_s  <= kd_q[bus.smp_ch];
            state <= S_ERR;
          end
        end
        S_ERR: begin
          e_q     <= e_w;
          i_q     <= i_new;
          d_q     <= d_w;
          sum_q   <= '0;
          start_q <= 1'b1;
          state   <= S_MUL_P;
        end
        S_MUL_P: begin
          if (mul_done) begin
            start_q <= 1'b1;
            state   <= S_MUL_I;
          end
        end
        S_MUL_I: begin
          // First cycle of each later term absorbs the previous finished product.
          if (start_q) sum_q <= sum_q + mul_prod;
          if (mul_done) begin
            start_q <= 1'b1;
            state   <= S_MUL_D;
          end
        end
        S_MUL_D: begin
          if (start_q) sum_q <= sum_q + mul_prod;
          if (mul_done) state <= S_SAT;
        end
        S_SAT: begin
          out_data_q  <= sat_w;
          out_ch_q    <= ch_q;
          out_valid_q <= 1'b1;
          state       <= S_OUT;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
